// File: rtl/icache_dm_pipe_pkg.sv
// Shared types and default geometry for the direct-mapped instruction cache.
package icache_dm_pipe_pkg;

    localparam int unsigned LADDR_W_DEF     = 39;
    localparam int unsigned SETS_DEF        = 64;
    localparam int unsigned LINE_BYTES_DEF  = 64;
    localparam int unsigned FETCH_BYTES_DEF = 16;

    // Default-geometry payload types; parametrised instances size their own buses.
    typedef logic [LADDR_W_DEF-1:0]       SC_laddr_type;
    typedef logic [FETCH_BYTES_DEF*8-1:0] SC_fetch_type;
    typedef logic [LINE_BYTES_DEF*8-1:0]  SC_line_type;

    typedef enum logic [1:0] {
        IC_STATE_IDLE      = 2'd0,
        IC_STATE_MISS_REQ  = 2'd1,
        IC_STATE_MISS_WAIT = 2'd2
    } ic_state_e;

endpackage

// File: rtl/icache_dm_pipe_if.sv
// Core fetch, L2 line request/fill and L2 snoop channels of the instruction cache.
interface icache_dm_pipe_if
    import icache_dm_pipe_pkg::*;
#(
    parameter int unsigned LADDR_W     = LADDR_W_DEF,
    parameter int unsigned LINE_BYTES  = LINE_BYTES_DEF,
    parameter int unsigned FETCH_BYTES = FETCH_BYTES_DEF
);

    logic                       coretoic_valid;
    logic                       coretoic_retry;
    logic [LADDR_W-1:0]         coretoic_pc;

    logic                       ictocore_valid;
    logic                       ictocore_retry;
    logic [FETCH_BYTES*8-1:0]   ictocore_data;

    logic                       l1tol2_req_valid;
    logic                       l1tol2_req_retry;
    logic [LADDR_W-1:0]         l1tol2_req_addr;

    logic                       l2tol1_snack_valid;
    logic                       l2tol1_snack_retry;
    logic [LINE_BYTES*8-1:0]    l2tol1_snack_data;

    logic                       l2tol1_snoop_valid;
    logic                       l2tol1_snoop_retry;
    logic [LADDR_W-1:0]         l2tol1_snoop_addr;

    logic                       l2tol1_snoop_ack_valid;
    logic                       l2tol1_snoop_ack_retry;

    // Core and L2 side.
    modport master (
        output coretoic_valid, coretoic_pc,
        input  coretoic_retry,
        input  ictocore_valid, ictocore_data,
        output ictocore_retry,
        input  l1tol2_req_valid, l1tol2_req_addr,
        output l1tol2_req_retry,
        output l2tol1_snack_valid, l2tol1_snack_data,
        input  l2tol1_snack_retry,
        output l2tol1_snoop_valid, l2tol1_snoop_addr,
        input  l2tol1_snoop_retry,
        input  l2tol1_snoop_ack_valid,
        output l2tol1_snoop_ack_retry
    );

    // Cache side.
    modport slave (
        input  coretoic_valid, coretoic_pc,
        output coretoic_retry,
        output ictocore_valid, ictocore_data,
        input  ictocore_retry,
        output l1tol2_req_valid, l1tol2_req_addr,
        input  l1tol2_req_retry,
        input  l2tol1_snack_valid, l2tol1_snack_data,
        output l2tol1_snack_retry,
        input  l2tol1_snoop_valid, l2tol1_snoop_addr,
        output l2tol1_snoop_retry,
        output l2tol1_snoop_ack_valid,
        input  l2tol1_snoop_ack_retry
    );

endinterface

// File: rtl/icache_dm_array.sv
// Tag and data storage: one combinational read port, one synchronous write port, no reset.
module icache_dm_array #(
    parameter int unsigned SETS   = 64,
    parameter int unsigned TAG_W  = 27,
    parameter int unsigned LINE_W = 512,
    parameter int unsigned IDX_W  = $clog2(SETS)
) (
    input  logic              clk,
    input  logic [IDX_W-1:0]  rd_idx_i,
    output logic [TAG_W-1:0]  rd_tag_o,
    output logic [LINE_W-1:0] rd_data_o,
    input  logic              wr_en_i,
    input  logic [IDX_W-1:0]  wr_idx_i,
    input  logic [TAG_W-1:0]  wr_tag_i,
    input  logic [LINE_W-1:0] wr_data_i
);

    logic [TAG_W-1:0]  tag_mem  [SETS];
    logic [LINE_W-1:0] data_mem [SETS];

    assign rd_tag_o  = tag_mem[rd_idx_i];
    assign rd_data_o = data_mem[rd_idx_i];

    // Install a fill line.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            tag_mem[wr_idx_i]  <= wr_tag_i;
            data_mem[wr_idx_i] <= wr_data_i;
        end
    end

endmodule

// File: rtl/icache_dm_pipe.sv
// Blocking direct-mapped instruction cache between core fetch and L2, with snoop invalidation.
module icache_dm_pipe
    import icache_dm_pipe_pkg::*;
#(
    parameter int unsigned LADDR_W     = LADDR_W_DEF,
    parameter int unsigned SETS        = SETS_DEF,
    parameter int unsigned LINE_BYTES  = LINE_BYTES_DEF,
    parameter int unsigned FETCH_BYTES = FETCH_BYTES_DEF
) (
    input  logic clk,
    input  logic reset,
    icache_dm_pipe_if.slave bus
);

    localparam int unsigned IDX_W   = $clog2(SETS);
    localparam int unsigned OFF_W   = $clog2(LINE_BYTES);
    localparam int unsigned TAG_W   = LADDR_W - IDX_W - OFF_W;
    localparam int unsigned LINE_W  = LINE_BYTES * 8;
    localparam int unsigned FETCH_W = FETCH_BYTES * 8;

    ic_state_e          state_q, state_d;
    logic [SETS-1:0]    valid_q, valid_d;
    logic               kill_q, kill_d;
    logic               out_valid_q, out_valid_d;
    logic [FETCH_W-1:0] out_data_q, out_data_d;
    logic               ack_valid_q, ack_valid_d;
    logic               req_valid_q, req_valid_d;
    logic [LADDR_W-1:0] miss_pc_q, miss_pc_d;

    logic [TAG_W-1:0]   pc_tag, snp_tag, miss_tag, rd_tag;
    logic [IDX_W-1:0]   pc_idx, snp_idx, miss_idx, rd_idx;
    logic [LINE_W-1:0]  rd_data;
    logic               out_free, core_acc, core_hit;
    logic               snoop_acc, snoop_hit, snoop_kills;
    logic               fill, fill_install;
    logic               unused_snoop_off;

    // Fetch block containing byte offset off, aligned down to the fetch width.
    function automatic logic [FETCH_W-1:0] sel_block(input logic [LINE_W-1:0] line,
                                                     input logic [OFF_W-1:0]  off);
        logic [OFF_W-1:0] aoff;
        aoff = off & ~OFF_W'(FETCH_BYTES - 1);
        return FETCH_W'(line >> {aoff, 3'b000});
    endfunction

    assign pc_tag   = bus.coretoic_pc[LADDR_W-1 -: TAG_W];
    assign pc_idx   = bus.coretoic_pc[OFF_W +: IDX_W];
    assign snp_tag  = bus.l2tol1_snoop_addr[LADDR_W-1 -: TAG_W];
    assign snp_idx  = bus.l2tol1_snoop_addr[OFF_W +: IDX_W];
    assign miss_tag = miss_pc_q[LADDR_W-1 -: TAG_W];
    assign miss_idx = miss_pc_q[OFF_W +: IDX_W];

    assign unused_snoop_off = ^bus.l2tol1_snoop_addr[OFF_W-1:0];

    // A pending snoop owns the single read port; the core is retried that cycle anyway.
    assign rd_idx = bus.l2tol1_snoop_valid ? snp_idx : pc_idx;

    assign out_free  = !out_valid_q || !bus.ictocore_retry;
    assign core_acc  = (state_q == IC_STATE_IDLE) && bus.coretoic_valid &&
                       !bus.l2tol1_snoop_valid && out_free && !reset;
    assign core_hit  = valid_q[pc_idx] && (rd_tag == pc_tag);

    assign snoop_acc = bus.l2tol1_snoop_valid && !ack_valid_q && !reset &&
                       ((state_q == IC_STATE_IDLE) || (state_q == IC_STATE_MISS_WAIT));
    assign snoop_hit   = valid_q[snp_idx] && (rd_tag == snp_tag);
    assign snoop_kills = (snp_tag == miss_tag) && (snp_idx == miss_idx);

    // A snoop landing on the fill's index in the same cycle keeps that line invalid.
    assign fill         = (state_q == IC_STATE_MISS_WAIT) && bus.l2tol1_snack_valid;
    assign fill_install = fill && !kill_q && !(snoop_acc && (snp_idx == miss_idx));

    icache_dm_array #(
        .SETS   (SETS),
        .TAG_W  (TAG_W),
        .LINE_W (LINE_W),
        .IDX_W  (IDX_W)
    ) u_array (
        .clk       (clk),
        .rd_idx_i  (rd_idx),
        .rd_tag_o  (rd_tag),
        .rd_data_o (rd_data),
        .wr_en_i   (fill_install),
        .wr_idx_i  (miss_idx),
        .wr_tag_i  (miss_tag),
        .wr_data_i (bus.l2tol1_snack_data)
    );

    // Next state, valid vector, output register, snoop ack and miss bookkeeping.
    always_comb begin
        state_d     = state_q;
        valid_d     = valid_q;
        kill_d      = kill_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        ack_valid_d = ack_valid_q && bus.l2tol1_snoop_ack_retry;
        req_valid_d = req_valid_q;
        miss_pc_d   = miss_pc_q;

        if (out_valid_q && !bus.ictocore_retry) begin
            out_valid_d = 1'b0;
        end

        if (snoop_acc) begin
            ack_valid_d = 1'b1;
            if (snoop_hit) begin
                valid_d[snp_idx] = 1'b0;
            end
        end

        case (state_q)
            IC_STATE_IDLE: begin
                if (core_acc) begin
                    if (core_hit) begin
                        out_valid_d = 1'b1;
                        out_data_d  = sel_block(rd_data, bus.coretoic_pc[OFF_W-1:0]);
                    end else begin
                        state_d     = IC_STATE_MISS_REQ;
                        req_valid_d = 1'b1;
                        miss_pc_d   = bus.coretoic_pc;
                    end
                end
            end
            IC_STATE_MISS_REQ: begin
                if (req_valid_q && !bus.l1tol2_req_retry) begin
                    req_valid_d = 1'b0;
                    state_d     = IC_STATE_MISS_WAIT;
                end
            end
            IC_STATE_MISS_WAIT: begin
                if (snoop_acc && snoop_kills) begin
                    kill_d = 1'b1;
                end
                if (fill) begin
                    out_valid_d = 1'b1;
                    out_data_d  = sel_block(bus.l2tol1_snack_data, miss_pc_q[OFF_W-1:0]);
                    if (fill_install) begin
                        valid_d[miss_idx] = 1'b1;
                    end
                    kill_d  = 1'b0;
                    state_d = IC_STATE_IDLE;
                end
            end
            default: state_d = IC_STATE_IDLE;
        endcase
    end

    // State registers with synchronous reset; tag/data arrays keep their contents.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IC_STATE_IDLE;
            valid_q     <= '0;
            kill_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            ack_valid_q <= 1'b0;
            req_valid_q <= 1'b0;
            miss_pc_q   <= '0;
        end else begin
            state_q     <= state_d;
            valid_q     <= valid_d;
            kill_q      <= kill_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            ack_valid_q <= ack_valid_d;
            req_valid_q <= req_valid_d;
            miss_pc_q   <= miss_pc_d;
        end
    end

    assign bus.coretoic_retry         = reset || (state_q != IC_STATE_IDLE) ||
                                        bus.l2tol1_snoop_valid || !out_free;
    assign bus.ictocore_valid         = out_valid_q;
    assign bus.ictocore_data          = out_data_q;
    assign bus.l1tol2_req_valid       = req_valid_q;
    assign bus.l1tol2_req_addr        = {miss_pc_q[LADDR_W-1:OFF_W], OFF_W'(0)};
    assign bus.l2tol1_snack_retry     = 1'b0;
    assign bus.l2tol1_snoop_retry     = reset || ack_valid_q || (state_q == IC_STATE_MISS_REQ);
    assign bus.l2tol1_snoop_ack_valid = ack_valid_q;

endmodule

// File: tb/tb_icache_dm_pipe.sv
// Directed bench for icache_dm_pipe at 64 sets, 64-byte lines, 16-byte fetch.
module tb_icache_dm_pipe;
    import icache_dm_pipe_pkg::*;

    typedef logic [511:0] cv_t;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    icache_dm_pipe_if bus ();

    icache_dm_pipe dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic chk(input string tag, input cv_t got, input cv_t exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // Line whose byte i is seed+i.
    function automatic SC_line_type mk_line(input logic [7:0] seed);
        SC_line_type l;
        for (int i = 0; i < 64; i++) l[8*i +: 8] = seed + 8'(i);
        return l;
    endfunction

    // Fetch block whose byte i is first+i.
    function automatic SC_fetch_type mk_blk(input logic [7:0] first);
        SC_fetch_type b;
        for (int i = 0; i < 16; i++) b[8*i +: 8] = first + 8'(i);
        return b;
    endfunction

    // Present a fetch until accepted; returns at the negedge after the accepting edge.
    task automatic fetch_issue(input SC_laddr_type pc);
        int n;
        n = 0;
        @(negedge clk);
        bus.coretoic_valid = 1'b1;
        bus.coretoic_pc    = pc;
        #1;
        while (bus.coretoic_retry && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("fetch_accept", cv_t'(bus.coretoic_retry), cv_t'(0));
        @(negedge clk);
        bus.coretoic_valid = 1'b0;
    endtask

    task automatic miss_req(input string tag, input SC_laddr_type pc, input SC_laddr_type exp_addr);
        fetch_issue(pc);
        chk({tag, "_reqv"}, cv_t'(bus.l1tol2_req_valid), cv_t'(1));
        chk({tag, "_addr"}, cv_t'(bus.l1tol2_req_addr), cv_t'(exp_addr));
        @(negedge clk);
        chk({tag, "_reqdone"}, cv_t'(bus.l1tol2_req_valid), cv_t'(0));
    endtask

    task automatic fill_line(input logic [7:0] seed);
        bus.l2tol1_snack_valid = 1'b1;
        bus.l2tol1_snack_data  = mk_line(seed);
        @(negedge clk);
        bus.l2tol1_snack_valid = 1'b0;
    endtask

    task automatic resp_chk(input string tag, input logic [7:0] first);
        chk({tag, "_rv"},   cv_t'(bus.ictocore_valid), cv_t'(1));
        chk({tag, "_data"}, cv_t'(bus.ictocore_data),  cv_t'(mk_blk(first)));
    endtask

    task automatic do_hit(input string tag, input SC_laddr_type pc, input logic [7:0] first);
        fetch_issue(pc);
        resp_chk(tag, first);
        chk({tag, "_noreq"}, cv_t'(bus.l1tol2_req_valid), cv_t'(0));
    endtask

    // Snoop from IDLE; hold keeps ack_retry high for that many extra cycles.
    task automatic snoop(input string tag, input SC_laddr_type addr, input int hold);
        @(negedge clk);
        bus.l2tol1_snoop_valid     = 1'b1;
        bus.l2tol1_snoop_addr      = addr;
        bus.l2tol1_snoop_ack_retry = (hold > 0);
        #1;
        chk({tag, "_acc"}, cv_t'(bus.l2tol1_snoop_retry), cv_t'(0));
        @(negedge clk);
        bus.l2tol1_snoop_valid = 1'b0;
        chk({tag, "_ack"}, cv_t'(bus.l2tol1_snoop_ack_valid), cv_t'(1));
        repeat (hold) begin
            @(negedge clk);
            chk({tag, "_ackhold"}, cv_t'(bus.l2tol1_snoop_ack_valid), cv_t'(1));
            chk({tag, "_busy"},    cv_t'(bus.l2tol1_snoop_retry),     cv_t'(1));
        end
        bus.l2tol1_snoop_ack_retry = 1'b0;
        @(negedge clk);
        chk({tag, "_ackdone"}, cv_t'(bus.l2tol1_snoop_ack_valid), cv_t'(0));
    endtask

    initial begin
        reset                      = 1'b1;
        bus.coretoic_valid         = 1'b0;
        bus.coretoic_pc            = '0;
        bus.ictocore_retry         = 1'b0;
        bus.l1tol2_req_retry       = 1'b0;
        bus.l2tol1_snack_valid     = 1'b0;
        bus.l2tol1_snack_data      = '0;
        bus.l2tol1_snoop_valid     = 1'b0;
        bus.l2tol1_snoop_addr      = '0;
        bus.l2tol1_snoop_ack_retry = 1'b0;

        repeat (2) @(negedge clk);
        chk("rst_core_retry", cv_t'(bus.coretoic_retry),         cv_t'(1));
        chk("rst_snp_retry",  cv_t'(bus.l2tol1_snoop_retry),     cv_t'(1));
        chk("rst_ic_valid",   cv_t'(bus.ictocore_valid),         cv_t'(0));
        chk("rst_req_valid",  cv_t'(bus.l1tol2_req_valid),       cv_t'(0));
        chk("rst_ack_valid",  cv_t'(bus.l2tol1_snoop_ack_valid), cv_t'(0));
        reset = 1'b0;
        #1;
        chk("idle_core_retry", cv_t'(bus.coretoic_retry),     cv_t'(0));
        chk("snack_retry",     cv_t'(bus.l2tol1_snack_retry), cv_t'(0));

        // Cold miss and hit in the same line.
        miss_req("cold", 39'h1010, 39'h1000);
        fill_line(8'h00);
        resp_chk("cold", 8'h10);
        do_hit("hit30", 39'h1030, 8'h30);

        // Conflict on index 0.
        miss_req("conf", 39'h2000, 39'h2000);
        fill_line(8'h80);
        resp_chk("conf", 8'h80);
        miss_req("back", 39'h1000, 39'h1000);
        fill_line(8'h00);
        resp_chk("back", 8'h00);

        // Snoop invalidation with a held ack, then a non-matching snoop.
        snoop("snp_hit", 39'h1000, 1);
        miss_req("postsnp", 39'h1000, 39'h1000);
        fill_line(8'h40);
        resp_chk("postsnp", 8'h40);
        snoop("snp_nom", 39'h5000, 0);
        do_hit("kept", 39'h1000, 8'h40);

        // Snoop to the missing line during MISS_WAIT kills the install.
        snoop("snp_inv", 39'h1000, 0);
        miss_req("kill", 39'h1000, 39'h1000);
        bus.l2tol1_snoop_valid = 1'b1;
        bus.l2tol1_snoop_addr  = 39'h1000;
        #1;
        chk("kill_snp_acc",   cv_t'(bus.l2tol1_snoop_retry), cv_t'(0));
        chk("miss_core_retry", cv_t'(bus.coretoic_retry),    cv_t'(1));
        @(negedge clk);
        bus.l2tol1_snoop_valid = 1'b0;
        chk("kill_ack", cv_t'(bus.l2tol1_snoop_ack_valid), cv_t'(1));
        fill_line(8'hC0);
        resp_chk("kill", 8'hC0);
        chk("kill_ackdone", cv_t'(bus.l2tol1_snoop_ack_valid), cv_t'(0));

        // Refetch misses; core back-pressure holds the fill block for 3 cycles.
        miss_req("rehold", 39'h1000, 39'h1000);
        bus.ictocore_retry = 1'b1;
        fill_line(8'h20);
        bus.coretoic_valid = 1'b1;
        bus.coretoic_pc    = 39'h1010;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("hold_rv",    cv_t'(bus.ictocore_valid), cv_t'(1));
            chk("hold_data",  cv_t'(bus.ictocore_data),  cv_t'(mk_blk(8'h20)));
            chk("hold_retry", cv_t'(bus.coretoic_retry), cv_t'(1));
            @(negedge clk);
        end
        bus.ictocore_retry = 1'b0;
        #1;
        chk("drain_accept", cv_t'(bus.coretoic_retry), cv_t'(0));
        @(negedge clk);
        bus.coretoic_valid = 1'b0;
        resp_chk("drain", 8'h30);
        chk("drain_noreq", cv_t'(bus.l1tol2_req_valid), cv_t'(0));

        // Reset mid-miss; a late fill is ignored and the cache is cold again.
        miss_req("rst", 39'h2000, 39'h2000);
        reset = 1'b1;
        #1;
        chk("mrst_core_retry", cv_t'(bus.coretoic_retry),     cv_t'(1));
        chk("mrst_snp_retry",  cv_t'(bus.l2tol1_snoop_retry), cv_t'(1));
        repeat (2) @(negedge clk);
        reset = 1'b0;
        fill_line(8'h55);
        chk("late_fill_rv",  cv_t'(bus.ictocore_valid),         cv_t'(0));
        chk("late_fill_req", cv_t'(bus.l1tol2_req_valid),       cv_t'(0));
        chk("late_fill_ack", cv_t'(bus.l2tol1_snoop_ack_valid), cv_t'(0));
        #1;
        chk("late_fill_idle", cv_t'(bus.coretoic_retry), cv_t'(0));
        miss_req("cold2", 39'h1030, 39'h1000);
        fill_line(8'h00);
        resp_chk("cold2", 8'h30);

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
